// File: rtl/pic10_fetch_unit.sv
// pic10_fetch_unit
// Program-counter and fetch stage of the PIC10 core. Drives the fetch
// address to program memory, captures the returned word into the
// instruction register, resolves GOTO/CALL/RETLW, PCL writes and skips,
// and holds the 2-level hardware return stack.
//
// Ports:
//   clk             system clock, all state on rising edge
//   reset           synchronous, active-high
//   program_bus     instruction word at pc_bus (combinational from memory)
//   skip_req        ALU skip result for the instruction in IR
//   pcl_write       IR instruction writes PCL this cycle
//   pcl_data        value written to PCL
//   pc_bus          current fetch address
//   instr           instruction register (execute stage)
//   instr_valid     0 when IR holds a flush/reset NOP
//   retlw_strobe    IR is a valid RETLW (W load request)
//   retlw_literal   RETLW literal, instr[7:0]
//   stack_depth     number of live stack entries, 0..2
//   stack_overflow  sticky, set by a push at depth 2
//   stack_underflow sticky, set by a pop at depth 0
module pic10_fetch_unit #(
    parameter logic [8:0]  RESET_VECTOR = 9'h1FF,
    parameter logic [11:0] NOP_WORD     = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] program_bus,
    input  logic        skip_req,
    input  logic        pcl_write,
    input  logic [7:0]  pcl_data,
    output logic [8:0]  pc_bus,
    output logic [11:0] instr,
    output logic        instr_valid,
    output logic        retlw_strobe,
    output logic [7:0]  retlw_literal,
    output logic [1:0]  stack_depth,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    logic [8:0] stack_top;
    logic [8:0] stack_next;

    logic       is_goto;
    logic       is_call;
    logic       is_retlw;
    logic       flush;
    logic [8:0] next_pc;

    // Decode is qualified by instr_valid so a flushed slot can never act as
    // a flow-change instruction, whatever NOP_WORD happens to be.
    always_comb begin
        is_goto  = instr_valid && (instr[11:9] == 3'b101);
        is_call  = instr_valid && (instr[11:8] == 4'b1001);
        is_retlw = instr_valid && (instr[11:8] == 4'b1000);
    end

    // Flow-change instructions outrank pcl_write; skip_req never moves the
    // PC, it only turns the word being fetched into a NOP.
    always_comb begin
        next_pc = pc_bus + 9'd1;
        if (is_goto) begin
            next_pc = instr[8:0];
        end else if (is_call) begin
            next_pc = {1'b0, instr[7:0]};
        end else if (is_retlw) begin
            next_pc = stack_top;
        end else if (pcl_write) begin
            next_pc = {1'b0, pcl_data};
        end
        flush = is_goto || is_call || is_retlw || pcl_write || skip_req;
    end

    // pc_bus already points at the word after the CALL, so it is pushed
    // directly as the return address. A pop keeps s1 (duplicated into s0),
    // so popping an empty stack still returns the last value seen there.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_bus          <= RESET_VECTOR;
            instr           <= NOP_WORD;
            instr_valid     <= 1'b0;
            stack_top       <= 9'd0;
            stack_next      <= 9'd0;
            stack_depth     <= 2'd0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            pc_bus      <= next_pc;
            instr       <= flush ? NOP_WORD : program_bus;
            instr_valid <= !flush;
            if (is_call) begin
                stack_next <= stack_top;
                stack_top  <= pc_bus;
                if (stack_depth == 2'd2) begin
                    stack_overflow <= 1'b1;
                end else begin
                    stack_depth <= stack_depth + 2'd1;
                end
            end else if (is_retlw) begin
                stack_top <= stack_next;
                if (stack_depth == 2'd0) begin
                    stack_underflow <= 1'b1;
                end else begin
                    stack_depth <= stack_depth - 2'd1;
                end
            end
        end
    end

    assign retlw_strobe  = is_retlw;
    assign retlw_literal = instr[7:0];

endmodule

// File: tb/tb_pic10_fetch_unit.sv
// Testbench for pic10_fetch_unit: a small program image drives program_bus,
// a behavioural model of the fetch stage tracks the expected outputs, and a
// compare process checks every output on every falling edge. Directed
// literal checks at key points pin the model itself.
module tb_pic10_fetch_unit;

    logic        clk;
    logic        reset;
    logic [11:0] program_bus;
    logic        skip_req;
    logic        pcl_write;
    logic [7:0]  pcl_data;
    logic [8:0]  pc_bus;
    logic [11:0] instr;
    logic        instr_valid;
    logic        retlw_strobe;
    logic [7:0]  retlw_literal;
    logic [1:0]  stack_depth;
    logic        stack_overflow;
    logic        stack_underflow;

    logic [11:0] mem [0:511];

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit   model_live = 0;
    int   m_pc;
    int   m_ir;
    bit   m_valid;
    int   m_stack [2];
    int   m_depth;
    bit   m_ovf;
    bit   m_unf;

    pic10_fetch_unit #(
        .RESET_VECTOR(9'h1FF),
        .NOP_WORD(12'h000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .program_bus(program_bus),
        .skip_req(skip_req),
        .pcl_write(pcl_write),
        .pcl_data(pcl_data),
        .pc_bus(pc_bus),
        .instr(instr),
        .instr_valid(instr_valid),
        .retlw_strobe(retlw_strobe),
        .retlw_literal(retlw_literal),
        .stack_depth(stack_depth),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    assign program_bus = mem[pc_bus];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Spec-level model: work out the instruction class from its opcode
    // bits, pick the new PC by priority, and decide whether the fetched
    // word survives.
    always @(posedge clk) begin
        int  fetched;
        int  new_pc;
        bit  do_goto, do_call, do_ret, discard;
        if (reset) begin
            m_pc = 'h1FF; m_ir = 0; m_valid = 0;
            m_stack[0] = 0; m_stack[1] = 0; m_depth = 0;
            m_ovf = 0; m_unf = 0;
            model_live = 1;
        end else if (model_live) begin
            fetched = int'(mem[m_pc]);
            do_goto = m_valid && ((m_ir >> 9) == 'b101);
            do_call = m_valid && ((m_ir >> 8) == 'h9);
            do_ret  = m_valid && ((m_ir >> 8) == 'h8);
            if (do_goto) begin
                new_pc = m_ir % 512;
            end else if (do_call) begin
                new_pc = m_ir % 256;
                m_stack[1] = m_stack[0];
                m_stack[0] = m_pc;
                if (m_depth == 2) m_ovf = 1; else m_depth++;
            end else if (do_ret) begin
                new_pc = m_stack[0];
                m_stack[0] = m_stack[1];
                if (m_depth == 0) m_unf = 1; else m_depth--;
            end else if (pcl_write) begin
                new_pc = int'(pcl_data);
            end else begin
                new_pc = (m_pc + 1) % 512;
            end
            discard = do_goto || do_call || do_ret || pcl_write || skip_req;
            m_ir    = discard ? 0 : fetched;
            m_valid = !discard;
            m_pc    = new_pc;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            checkOutput("pc_bus", int'(pc_bus), m_pc);
            checkOutput("instr", int'(instr), m_ir);
            checkOutput("instr_valid", int'(instr_valid), int'(m_valid));
            checkOutput("retlw_strobe", int'(retlw_strobe), int'(m_valid && ((m_ir >> 8) == 'h8)));
            checkOutput("retlw_literal", int'(retlw_literal), m_ir % 256);
            checkOutput("stack_depth", int'(stack_depth), m_depth);
            checkOutput("stack_overflow", int'(stack_overflow), int'(m_ovf));
            checkOutput("stack_underflow", int'(stack_underflow), int'(m_unf));
        end
    end

    task automatic applyStimulus(input bit rst, input bit skip, input bit pclw, input logic [7:0] pcld);
        reset     = rst;
        skip_req  = skip;
        pcl_write = pclw;
        pcl_data  = pcld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 12'h000;
        mem[9'h003] = 12'hA55;  // GOTO 0x055
        mem[9'h055] = 12'h123;
        mem[9'h056] = 12'hA10;  // GOTO 0x010
        mem[9'h010] = 12'h940;  // CALL 0x40
        mem[9'h040] = 12'h87A;  // RETLW 0x7A
        mem[9'h011] = 12'h960;  // CALL 0x60
        mem[9'h060] = 12'h970;  // CALL 0x70
        mem[9'h070] = 12'h980;  // CALL 0x80 (third push, overflow)
        mem[9'h080] = 12'h811;  // RETLW
        mem[9'h071] = 12'h822;  // RETLW
        mem[9'h061] = 12'h833;  // RETLW
        mem[9'h020] = 12'h2A5;
        mem[9'h021] = 12'h3B6;  // skipped word
        mem[9'h022] = 12'h4C7;
        mem[9'h0C3] = 12'hBF0;  // GOTO 0x1F0
        mem[9'h1F0] = 12'h9AB;  // CALL 0xAB

        reset = 1'b1; skip_req = 1'b0; pcl_write = 1'b0; pcl_data = 8'h00;

        // Reset and PC wrap
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("reset pc", int'(pc_bus), 'h1FF);
        checkOutput("reset valid", int'(instr_valid), 0);
        checkOutput("reset depth", int'(stack_depth), 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("wrap pc", int'(pc_bus), 'h000);
        checkOutput("wrap valid", int'(instr_valid), 1);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("pc 002", int'(pc_bus), 'h002);

        // GOTO
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("goto ir", int'(instr), 'hA55);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("goto pc", int'(pc_bus), 'h055);
        checkOutput("goto flush valid", int'(instr_valid), 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("goto target ir", int'(instr), 'h123);
        checkOutput("goto target valid", int'(instr_valid), 1);

        // CALL / RETLW
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("call pc", int'(pc_bus), 'h040);
        checkOutput("call depth", int'(stack_depth), 1);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("retlw strobe", int'(retlw_strobe), 1);
        checkOutput("retlw literal", int'(retlw_literal), 'h7A);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("retlw pc", int'(pc_bus), 'h011);
        checkOutput("retlw depth", int'(stack_depth), 0);
        checkOutput("retlw flush strobe", int'(retlw_strobe), 0);

        // Nested CALLs to overflow, then RETLWs to underflow
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 8'h00);
        checkOutput("ovf pc", int'(pc_bus), 'h080);
        checkOutput("ovf depth", int'(stack_depth), 2);
        checkOutput("ovf flag", int'(stack_overflow), 1);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("ret1 pc", int'(pc_bus), 'h071);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("ret2 pc", int'(pc_bus), 'h061);
        checkOutput("ret2 underflow", int'(stack_underflow), 0);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("ret3 pc", int'(pc_bus), 'h061);
        checkOutput("ret3 underflow", int'(stack_underflow), 1);
        checkOutput("ret3 depth", int'(stack_depth), 0);

        // Skip
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("reset clears ovf", int'(stack_overflow), 0);
        checkOutput("reset clears unf", int'(stack_underflow), 0);
        applyStimulus(0, 0, 1, 8'h20);
        checkOutput("pcl after reset pc", int'(pc_bus), 'h020);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("pre-skip ir", int'(instr), 'h2A5);
        applyStimulus(0, 1, 0, 8'h00);
        checkOutput("skip pc", int'(pc_bus), 'h022);
        checkOutput("skip ir", int'(instr), 'h000);
        checkOutput("skip valid", int'(instr_valid), 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("post-skip ir", int'(instr), 'h4C7);

        // PCL write and priority
        applyStimulus(0, 0, 1, 8'hC3);
        checkOutput("pcl pc", int'(pc_bus), 'h0C3);
        checkOutput("pcl flush valid", int'(instr_valid), 0);
        applyStimulus(0, 0, 0, 8'h00);
        applyStimulus(0, 1, 1, 8'h55);
        checkOutput("goto over pcl pc", int'(pc_bus), 'h1F0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("call in ir", int'(instr), 'h9AB);
        applyStimulus(1, 0, 0, 8'h00);
        checkOutput("reset over call pc", int'(pc_bus), 'h1FF);
        checkOutput("reset over call depth", int'(stack_depth), 0);
        checkOutput("reset over call valid", int'(instr_valid), 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("post reset pc", int'(pc_bus), 'h000);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
